inv_sub_bytes: RTL and testbench
================================

INV_SUB_BYTES -- requirements
Module: inv_sub_bytes

Interface
REQ-001 The block SHALL have no parameters; all sizes are fixed constants from the shared package.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  din holds a 128-bit AES state to transform.
REQ-005 in_ready  output  1  block can accept a state; high only in IDLE.
REQ-006 din  input  128  input state; byte i = din[127-8i -: 8], FIPS-197 column-major (row i%4, column i/4).
REQ-007 out_valid  output  1  dout holds a completed result.
REQ-008 out_ready  input  1  downstream accepts dout.
REQ-009 dout  output  128  result state, same byte ordering as din.

Function
REQ-010 Each result byte SHALL be the AES inverse S-box of one input byte, via a single shared inv_sbox lookup with 1-cycle registered latency.
REQ-011 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on in_valid&&in_ready; RUN->DONE after byte 15 is written; DONE->IDLE on out_valid&&out_ready.
REQ-012 On acceptance, din SHALL be captured in an internal 128-bit register; din is don't-care afterwards.
REQ-013 In RUN, a 4-bit issue counter SHALL drive captured byte k to the lookup in the k-th cycle after acceptance (k=0..15), then stop; no wrap.
REQ-014 Lookup result for byte k SHALL be written into the result register one cycle after it is returned (write pointer = issue index delayed by the lookup latency).
REQ-015 out_valid SHALL rise on the 17th rising edge after the accepting edge, same edge as the byte-15 write.
REQ-016 While out_valid && !out_ready, dout and out_valid SHALL hold stable; in_ready stays low.
REQ-017 in_valid SHALL be ignored outside IDLE; no queueing of a second state.
REQ-018 After the output handshake edge, in_ready SHALL be high the following cycle; minimum accept-to-accept spacing 19 cycles with out_ready held high.
REQ-019 Data SHALL never be dropped: a result leaves only via out_valid&&out_ready.

Reset
REQ-020 rst SHALL asynchronously force: state IDLE, counters 0, out_valid 0, dout 128'h0, captured state 0; in_ready high while rst is low and state IDLE.
REQ-021 rst asserted mid-RUN or in DONE SHALL discard the in-flight state; no out_valid pulse after release.
REQ-022 The inv_sbox output is unreset; the block SHALL not consume it except in the cycle after a valid issue.

Configuration
REQ-023 Macro INV_SHIFT_ROWS_EN: when defined, the result write SHALL also apply InvShiftRows: out[r][c] = InvS(in[r][(c-r) mod 4]), i.e. byte from input index 4*((c-r) mod 4)+r lands at index 4c+r.
REQ-024 When INV_SHIFT_ROWS_EN is undefined, output byte index SHALL equal input byte index (pure InvSubBytes); latency and handshake identical in both builds.

Structure
REQ-025 Shared package aes_pkg SHALL hold: AES_STATE_W=128, AES_NUM_BYTES=16, byte index width 4, FSM state type {IDLE, RUN, DONE}, and the InvShiftRows index function.
REQ-026 One sub-module: the existing inv_sbox, instantiated once, fed by the issue mux, clocked by clk.

Verification
REQ-027 din all bytes 0x63, out_ready high -> out_valid after exactly 17 edges, dout = 128'h0.
REQ-028 din all bytes 0x00 -> dout all bytes 0x52; din all 0x16 -> dout all 0xFF.
REQ-029 din all 0x63 except byte 1 = 0x7C -> without macro dout byte 1 = 0x01; with INV_SHIFT_ROWS_EN dout byte 5 = 0x01; all other bytes 0x00.
REQ-030 out_ready low 5 cycles after out_valid -> dout/out_valid stable, in_ready low, in_valid pulses ignored; handshake on 6th cycle, in_ready high next cycle.
REQ-031 rst asserted at issue count 8 -> out_valid 0, dout 0 immediately; after release, in_ready high, next state 0x52-pattern completes normally.
REQ-032 Back-to-back: two states presented continuously, out_ready high -> second accepted 19 cycles after first, both results correct and in order.

Source files
------------

// File: rtl/inv_sub_bytes_pkg.sv
// Shared AES constants and types for the InvSubBytes block.
// Holds the state/byte sizes, the control FSM state type and the
// InvShiftRows destination-index helper used when INV_SHIFT_ROWS_EN is set.
package aes_pkg;
  localparam int AES_STATE_W   = 128;
  localparam int AES_NUM_BYTES = 16;
  localparam int AES_IDX_W     = 4;

  typedef logic [AES_IDX_W-1:0] byte_idx_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} aes_state_e;

  // Input byte k sits at row k%4, column k/4; InvShiftRows moves row r
  // right by r columns, so it lands at column (c+r) mod 4 of the same row.
  function automatic byte_idx_t isr_dst(input byte_idx_t k);
    logic [1:0] r, c;
    r = k[1:0];
    c = k[3:2] + r;
    return {c, r};
  endfunction
endpackage

// File: rtl/inv_sub_bytes_if.sv
// Ready/valid bus carrying one 128-bit AES state in and one result out.
interface inv_sub_bytes_if;
  import aes_pkg::*;
  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] din;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] dout;

  modport master (output in_valid, din, out_ready,
                  input  in_ready, out_valid, dout);
  modport slave  (input  in_valid, din, out_ready,
                  output in_ready, out_valid, dout);
endinterface

// File: rtl/inv_sub_bytes_inv_sbox.sv
// AES inverse S-box: one byte lookup, registered output, no reset on the
// output register (the consumer tracks validity itself).
module inv_sbox (
  input  logic       clk,
  input  logic [7:0] a,
  output logic [7:0] q
);
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Registered table lookup.
  always_ff @(posedge clk)
    q <= INV_SBOX[a];
endmodule

// File: rtl/inv_sub_bytes.sv
// Byte-serial AES InvSubBytes: captures a 128-bit state, streams its 16
// bytes through one shared inverse S-box and assembles the result.
// Optional build macro INV_SHIFT_ROWS_EN additionally applies InvShiftRows
// at the result write; latency and handshake are unchanged.
module inv_sub_bytes
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  inv_sub_bytes_if.slave bus
);
  localparam int LAT = 1;  // inv_sbox lookup latency

  aes_state_e                    st, st_nxt;
  logic [0:AES_NUM_BYTES-1][7:0] cap, res;
  byte_idx_t                     iss_cnt, wr_idx, wr_dst;
  logic                          iss_done, iss_vld, acc;
  logic [LAT-1:0]                vld_pipe;
  logic [7:0]                    sbox_q;

  assign bus.in_ready  = (st == IDLE) && !rst;
  assign bus.out_valid = (st == DONE);
  assign bus.dout      = res;
  assign acc           = bus.in_valid && bus.in_ready;
  assign iss_vld       = (st == RUN) && !iss_done;

`ifdef INV_SHIFT_ROWS_EN
  assign wr_dst = isr_dst(wr_idx);
`else
  assign wr_dst = wr_idx;
`endif

  inv_sbox u_sbox (
    .clk (clk),
    .a   (cap[iss_cnt]),
    .q   (sbox_q)
  );

  // State register.
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else     st <= st_nxt;

  // Next state: leave RUN on the edge that writes the last byte.
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (acc) st_nxt = RUN;
      RUN:     if (vld_pipe[LAT-1] && wr_idx == byte_idx_t'(AES_NUM_BYTES-1))
                 st_nxt = DONE;
      DONE:    if (bus.out_ready) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // Capture, issue counter (saturates at 15), lookup-valid pipe, result write.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cap      <= '0;
      res      <= '0;
      iss_cnt  <= '0;
      iss_done <= 1'b0;
      vld_pipe <= '0;
      wr_idx   <= '0;
    end else begin
      if (acc) begin
        cap      <= bus.din;
        iss_cnt  <= '0;
        iss_done <= 1'b0;
      end else if (iss_vld) begin
        if (iss_cnt == byte_idx_t'(AES_NUM_BYTES-1)) iss_done <= 1'b1;
        else                                         iss_cnt  <= iss_cnt + 1'b1;
      end
      vld_pipe[0] <= iss_vld;
      if (iss_vld) wr_idx <= iss_cnt;
      if (vld_pipe[LAT-1]) res[wr_dst] <= sbox_q;
    end
endmodule

// File: tb/tb_inv_sub_bytes.sv
// Scoreboard bench for inv_sub_bytes: reference inverse S-box derived from
// GF(2^8) inversion plus the affine map; directed and random states.
module tb_inv_sub_bytes;
  logic clk = 1'b0;
  logic rst;
  logic rand_rdy = 1'b0, rdy_force = 1'b1, rnd = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0, n_err = 0;
  logic [127:0] exp_q[$];
  int           acc_q[$];
  int           last_acc;
  logic [7:0]   inv_tab [256];
  logic         prev_ov = 1'b0, prev_hs = 1'b0;
  logic [127:0] prev_dout = '0;

  inv_sub_bytes_if bus();

  inv_sub_bytes dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd <= 1'($urandom_range(0, 1));
  assign bus.out_ready = rand_rdy ? rnd : rdy_force;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward S-box = affine(GF inverse); invert it into inv_tab.
  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b = 8'h00, s;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      s = b ^ rol(b, 1) ^ rol(b, 2) ^ rol(b, 3) ^ rol(b, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d);
    logic [0:15][7:0] i, o;
    i = d;
    for (int k = 0; k < 16; k++) begin
      int r = k % 4, c = k / 4, src;
`ifdef INV_SHIFT_ROWS_EN
      src = 4 * ((c - r + 4) % 4) + r;
`else
      src = k;
`endif
      o[k] = inv_tab[i[src]];
    end
    return o;
  endfunction

  function automatic logic [127:0] fill(input logic [7:0] b);
    logic [0:15][7:0] v;
    for (int k = 0; k < 16; k++) v[k] = b;
    return v;
  endfunction

  // Present d until accepted; returns on the negedge after the accepting edge.
  task automatic send(input logic [127:0] d, input logic [127:0] e, input bit keep);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.din      = d;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("accept_timeout", 128'(bus.in_ready), 128'd1);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    last_acc = cyc + 1;
    acc_q.push_back(last_acc);
    @(negedge clk);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 128'(exp_q.size()), 128'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: latency, stability under backpressure, in_ready after handshake,
  // and result comparison on every output handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) check("in_ready_after_hs", 128'(bus.in_ready), 128'd1);
      if (bus.out_valid) begin
        if (!prev_ov) begin
          if (acc_q.size() == 0) check("spurious_out_valid", 128'd1, 128'd0);
          else                   check("latency", 128'(cyc - acc_q[0]), 128'd17);
        end else if (!prev_hs) begin
          check("dout_stable", bus.dout, prev_dout);
          check("in_ready_low_hold", 128'(bus.in_ready), 128'd0);
        end
        if (bus.out_ready) begin
          if (exp_q.size() == 0) check("spurious_result", 128'd1, 128'd0);
          else begin
            check("dout", bus.dout, exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      prev_ov   = bus.out_valid;
      prev_dout = bus.dout;
      prev_hs   = bus.out_valid && bus.out_ready;
    end
  end

  initial begin
    logic [0:15][7:0] v, e;
    logic [127:0] r1, r2;
    int a1, n;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.din = '0;
    build_model();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_dout", bus.dout, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 128'(bus.in_ready), 128'd1);

    // Directed patterns with hand-known answers
    send(fill(8'h63), 128'h0, 1'b0);
    drain();
    send(fill(8'h00), fill(8'h52), 1'b0);
    drain();
    send(fill(8'h16), fill(8'hff), 1'b0);
    drain();
    v = fill(8'h63); v[1] = 8'h7c;
    e = '0;
`ifdef INV_SHIFT_ROWS_EN
    e[5] = 8'h01;
`else
    e[1] = 8'h01;
`endif
    send(v, e, 1'b0);
    drain();

    // Backpressure: hold out_ready low 5 cycles with stray in_valid pulses
    rdy_force = 1'b0;
    r1 = {$urandom, $urandom, $urandom, $urandom};
    send(r1, model(r1), 1'b0);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", 128'(bus.out_valid), 128'd1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'(i % 2 == 0);
      bus.din = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rdy_force = 1'b1;
    drain();

    // Reset in the middle of RUN (issue count 8)
    send(fill(8'h11), fill(8'h00), 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("midrun_rst_dout", bus.dout, 128'h0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(bus.in_ready), 128'd1);
    repeat (25) @(negedge clk);
    send(fill(8'h00), fill(8'h52), 1'b0);
    drain();

    // Back-to-back states with out_ready high
    r1 = {$urandom, $urandom, $urandom, $urandom};
    r2 = {$urandom, $urandom, $urandom, $urandom};
    send(r1, model(r1), 1'b1);
    a1 = last_acc;
    send(r2, model(r2), 1'b0);
    check("b2b_spacing", 128'(last_acc - a1), 128'd19);
    drain();

    // Random states with random downstream backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      r1 = {$urandom, $urandom, $urandom, $urandom};
      send(r1, model(r1), 1'($urandom_range(0, 1)));
    end
    bus.in_valid = 1'b0;
    drain();
    rand_rdy = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
